// File: rtl/ysyx_24110006_wbu_if.sv
// ysyx_24110006_wbu_if: result/commit/hazard bus between the pipeline and the writeback buffer.
//   master: upstream result producer and commit control (drives i_*, observes o_*)
//   slave : writeback buffer (observes i_*, drives o_*)
//   Forwarding signals exist only when YSYX_24110006_WBU_FORWARD_EN is defined.
interface ysyx_24110006_wbu_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  i_in_valid;
    logic                  o_in_ready;
    logic [ADDR_WIDTH-1:0] i_rd;
    logic                  i_rd_wen;
    logic [DATA_WIDTH-1:0] i_result;
    logic                  i_commit_en;
    logic                  i_flush;
    logic                  o_valid;
    logic                  o_wen;
    logic [ADDR_WIDTH-1:0] o_waddr;
    logic [DATA_WIDTH-1:0] o_wdata;
    logic [ADDR_WIDTH-1:0] i_raddr1;
    logic [ADDR_WIDTH-1:0] i_raddr2;
    logic                  o_hazard1;
    logic                  o_hazard2;
    logic [31:0]           o_retire_cnt;
`ifdef YSYX_24110006_WBU_FORWARD_EN
    logic                  o_fwd_hit1;
    logic                  o_fwd_hit2;
    logic [DATA_WIDTH-1:0] o_fwd_data1;
    logic [DATA_WIDTH-1:0] o_fwd_data2;

    modport master (
        output i_in_valid, i_rd, i_rd_wen, i_result, i_commit_en, i_flush, i_raddr1, i_raddr2,
        input  o_in_ready, o_valid, o_wen, o_waddr, o_wdata, o_hazard1, o_hazard2, o_retire_cnt,
        input  o_fwd_hit1, o_fwd_hit2, o_fwd_data1, o_fwd_data2
    );
    modport slave (
        input  i_in_valid, i_rd, i_rd_wen, i_result, i_commit_en, i_flush, i_raddr1, i_raddr2,
        output o_in_ready, o_valid, o_wen, o_waddr, o_wdata, o_hazard1, o_hazard2, o_retire_cnt,
        output o_fwd_hit1, o_fwd_hit2, o_fwd_data1, o_fwd_data2
    );
`else
    modport master (
        output i_in_valid, i_rd, i_rd_wen, i_result, i_commit_en, i_flush, i_raddr1, i_raddr2,
        input  o_in_ready, o_valid, o_wen, o_waddr, o_wdata, o_hazard1, o_hazard2, o_retire_cnt
    );
    modport slave (
        input  i_in_valid, i_rd, i_rd_wen, i_result, i_commit_en, i_flush, i_raddr1, i_raddr2,
        output o_in_ready, o_valid, o_wen, o_waddr, o_wdata, o_hazard1, o_hazard2, o_retire_cnt
    );
`endif
endinterface

// File: rtl/ysyx_24110006_wbu.sv
// ysyx_24110006_wbu: in-order writeback buffer between execute results and the register file.
//   i_clock    : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   bus (slave): enqueue handshake (i_in_valid/o_in_ready, i_rd, i_rd_wen, i_result),
//                retire control (i_commit_en, i_flush), register-file write port
//                (o_valid, o_wen, o_waddr, o_wdata), hazard lookup (i_raddrK -> o_hazardK),
//                retired-entry counter o_retire_cnt.
//   Define YSYX_24110006_WBU_FORWARD_EN to add youngest-match forwarding
//   (o_fwd_hit1/2, o_fwd_data1/2) on the interface.
module ysyx_24110006_wbu #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    ysyx_24110006_wbu_if.slave      bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [31:0]           retire_cnt;
    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic                  wen_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      live;
    logic                  in_ready;
    logic                  out_valid;
    logic                  enq;
    logic                  deq;
    logic                  hz1;
    logic                  hz2;

    // Handshake and retire qualifiers; flush blocks both.
    assign in_ready  = (count != CNT_W'(DEPTH)) && !bus.i_flush;
    assign out_valid = (count != '0) && bus.i_commit_en && !bus.i_flush;
    assign enq       = bus.i_in_valid && in_ready;
    assign deq       = out_valid;

    assign bus.o_in_ready   = in_ready;
    assign bus.o_valid      = out_valid;
    assign bus.o_waddr      = rd_q[rd_ptr];
    assign bus.o_wdata      = data_q[rd_ptr];
    // Gated on occupancy so uninitialised storage never reaches the write enable.
    assign bus.o_wen        = (count != '0) && wen_q[rd_ptr] && (rd_q[rd_ptr] != '0);
    assign bus.o_retire_cnt = retire_cnt;
    assign bus.o_hazard1    = hz1 && (bus.i_raddr1 != '0);
    assign bus.o_hazard2    = hz2 && (bus.i_raddr2 != '0);

    // Control state: pointers, occupancy and retire counter.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            retire_cnt <= '0;
        end else if (bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                retire_cnt <= retire_cnt + 32'd1;
            end
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Entry storage is deliberately left without reset.
    always_ff @(posedge i_clock) begin
        if (enq) begin
            rd_q[wr_ptr]   <= bus.i_rd;
            wen_q[wr_ptr]  <= bus.i_rd_wen;
            data_q[wr_ptr] <= bus.i_result;
        end
    end

    // Occupied-slot mask: slot at offset i from the head is live when i < count.
    always_comb begin
        live = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (CNT_W'(i) < count) live[rd_ptr + PTR_W'(i)] = 1'b1;
        end
    end

    // Pending-write lookup over every live entry, head included.
    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
        for (int j = 0; j < int'(DEPTH); j++) begin
            if (live[j] && wen_q[j] && (rd_q[j] == bus.i_raddr1)) hz1 = 1'b1;
            if (live[j] && wen_q[j] && (rd_q[j] == bus.i_raddr2)) hz2 = 1'b1;
        end
    end

`ifdef YSYX_24110006_WBU_FORWARD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        bus.o_fwd_hit1  = 1'b0;
        bus.o_fwd_hit2  = 1'b0;
        bus.o_fwd_data1 = '0;
        bus.o_fwd_data2 = '0;
        fwd_idx         = rd_ptr;
        for (int i = 0; i < int'(DEPTH); i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && wen_q[fwd_idx] && (rd_q[fwd_idx] != '0)) begin
                if (rd_q[fwd_idx] == bus.i_raddr1) begin
                    bus.o_fwd_hit1  = 1'b1;
                    bus.o_fwd_data1 = data_q[fwd_idx];
                end
                if (rd_q[fwd_idx] == bus.i_raddr2) begin
                    bus.o_fwd_hit2  = 1'b1;
                    bus.o_fwd_data2 = data_q[fwd_idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24110006_wbu.sv
// tb_ysyx_24110006_wbu: directed scenarios plus randomized traffic, checked cycle by cycle
// against a queue-based reference model of the writeback buffer.
module tb_ysyx_24110006_wbu;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic          wen;
        logic [DW-1:0] data;
    } ent_t;

    logic        clk;
    logic        rst_n;
    int          n_tests;
    int          n_fail;
    ent_t        q[$];
    logic [31:0] m_retire;
    logic [31:0] snap;

    ysyx_24110006_wbu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_24110006_wbu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every combinational output against the model for the current inputs.
    task automatic check_outputs();
        int   cnt;
        logic hz1;
        logic hz2;
        cnt = q.size();
        hz1 = 1'b0;
        hz2 = 1'b0;
        foreach (q[k]) begin
            if (q[k].wen && q[k].rd == bus.i_raddr1 && bus.i_raddr1 != 0) hz1 = 1'b1;
            if (q[k].wen && q[k].rd == bus.i_raddr2 && bus.i_raddr2 != 0) hz2 = 1'b1;
        end
        check("in_ready", bus.o_in_ready, (cnt != DEPTH) && !bus.i_flush);
        check("valid", bus.o_valid, (cnt != 0) && bus.i_commit_en && !bus.i_flush);
        check("wen", bus.o_wen, (cnt != 0) && q[0].wen && (q[0].rd != 0));
        if (cnt != 0) begin
            check("waddr", bus.o_waddr, q[0].rd);
            check("wdata", bus.o_wdata, q[0].data);
        end
        check("hazard1", bus.o_hazard1, hz1);
        check("hazard2", bus.o_hazard2, hz2);
        check("retire_cnt", bus.o_retire_cnt, m_retire);
`ifdef YSYX_24110006_WBU_FORWARD_EN
        begin
            logic          h1, h2;
            logic [DW-1:0] d1, d2;
            h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
            foreach (q[k]) begin
                if (q[k].wen && q[k].rd != 0 && q[k].rd == bus.i_raddr1) begin h1 = 1'b1; d1 = q[k].data; end
                if (q[k].wen && q[k].rd != 0 && q[k].rd == bus.i_raddr2) begin h2 = 1'b1; d2 = q[k].data; end
            end
            check("fwd_hit1", bus.o_fwd_hit1, h1);
            check("fwd_hit2", bus.o_fwd_hit2, h2);
            if (h1) check("fwd_data1", bus.o_fwd_data1, d1);
            if (h2) check("fwd_data2", bus.o_fwd_data2, d2);
        end
`endif
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input logic v, input logic [AW-1:0] rd, input logic w, input logic [DW-1:0] d,
                         input logic c, input logic f, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        logic will_deq;
        logic will_enq;
        @(negedge clk);
        bus.i_in_valid  = v;
        bus.i_rd        = rd;
        bus.i_rd_wen    = w;
        bus.i_result    = d;
        bus.i_commit_en = c;
        bus.i_flush     = f;
        bus.i_raddr1    = a1;
        bus.i_raddr2    = a2;
        #1;
        check_outputs();
        will_deq = !f && c && (q.size() != 0);
        will_enq = !f && v && (q.size() != DEPTH);
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
        end else begin
            if (will_deq) begin
                void'(q.pop_front());
                m_retire = m_retire + 32'd1;
            end
            if (will_enq) q.push_back('{rd: rd, wen: w, data: d});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_retire = '0;
        rst_n = 1'b0;
        bus.i_in_valid = 1'b0; bus.i_rd = '0; bus.i_rd_wen = 1'b0; bus.i_result = '0;
        bus.i_commit_en = 1'b0; bus.i_flush = 1'b0; bus.i_raddr1 = '0; bus.i_raddr2 = '0;
        #7;
        check("rst_in_ready", bus.o_in_ready, 1'b1);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_wen", bus.o_wen, 1'b0);
        check("rst_retire", bus.o_retire_cnt, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Single result, minimum latency.
        cycle(1, 5'd5, 1, 32'hDEADBEEF, 1, 0, 5'd5, 5'd0);
        cycle(0, 5'd0, 0, 32'h0, 1, 0, 5'd5, 5'd0);
        check("s1_retire", bus.o_retire_cnt, 32'd1);
        check("s1_empty_valid", bus.o_valid, 1'b0);

        // Fill with commit held off, reject third, then drain in order.
        cycle(1, 5'd1, 1, 32'h11, 0, 0, 5'd1, 5'd2);
        cycle(1, 5'd2, 1, 32'h22, 0, 0, 5'd1, 5'd2);
        cycle(1, 5'd3, 1, 32'h33, 0, 0, 5'd3, 5'd2);
        cycle(0, 5'd0, 0, 32'h0, 1, 0, 5'd3, 5'd1);
        cycle(0, 5'd0, 0, 32'h0, 1, 0, 5'd2, 5'd1);
        cycle(0, 5'd0, 0, 32'h0, 1, 0, 5'd2, 5'd1);

        // Full with commit: no enqueue, then enqueue and retire together.
        cycle(1, 5'd4, 1, 32'h44, 0, 0, 5'd4, 5'd0);
        cycle(1, 5'd6, 1, 32'h66, 0, 0, 5'd6, 5'd4);
        cycle(1, 5'd8, 1, 32'h88, 1, 0, 5'd8, 5'd6);
        cycle(1, 5'd9, 1, 32'h99, 1, 0, 5'd9, 5'd8);
        check("s3_ready_count1", bus.o_in_ready, 1'b1);
        cycle(0, 5'd0, 0, 32'h0, 1, 0, 5'd9, 5'd0);

        // Non-writing entries: rd=0 with wen, rd=7 without wen.
        snap = bus.o_retire_cnt;
        cycle(1, 5'd0, 1, 32'hA0, 0, 0, 5'd0, 5'd7);
        cycle(1, 5'd7, 0, 32'hA7, 0, 0, 5'd0, 5'd7);
        cycle(0, 5'd0, 0, 32'h0, 1, 0, 5'd0, 5'd7);
        cycle(0, 5'd0, 0, 32'h0, 1, 0, 5'd0, 5'd7);
        check("s4_retire_delta", bus.o_retire_cnt - snap, 32'd2);

        // Flush with concurrent valid input.
        cycle(1, 5'd10, 1, 32'hB0, 0, 0, 5'd10, 5'd11);
        cycle(1, 5'd11, 1, 32'hB1, 0, 0, 5'd10, 5'd11);
        snap = bus.o_retire_cnt;
        cycle(1, 5'd12, 1, 32'hB2, 1, 1, 5'd10, 5'd12);
        cycle(0, 5'd0, 0, 32'h0, 1, 0, 5'd10, 5'd12);
        check("s5_retire_same", bus.o_retire_cnt, snap);

        // Asynchronous reset mid-cycle with one entry pending.
        cycle(1, 5'd3, 1, 32'hC3, 0, 0, 5'd3, 5'd0);
        @(negedge clk);
        bus.i_in_valid = 1'b0; bus.i_commit_en = 1'b1; bus.i_raddr1 = 5'd3;
        #1;
        check("s6_pre_valid", bus.o_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("s6_rst_valid", bus.o_valid, 1'b0);
        check("s6_rst_retire", bus.o_retire_cnt, 32'd0);
        check("s6_rst_hazard", bus.o_hazard1, 1'b0);
        check("s6_rst_ready", bus.o_in_ready, 1'b1);
        q.delete();
        m_retire = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  32'($urandom), 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 5),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
